mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter (store > load > fetch) sharing one memory port; one read in flight, MEM_LAT-cycle return.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:1] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [15:0] fetch_rdata,
  input  logic        ld_req,
  input  logic [15:1] ld_addr,
  output logic        ld_gnt,
  output logic        ld_rvalid,
  output logic [15:0] ld_rdata,
  input  logic        st_req,
  input  logic [15:1] st_addr,
  input  logic [15:0] st_data,
  output logic        st_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:1] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  stall_num
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  busy_cnt_q, busy_cnt_d;
  logic        tag_q, tag_d;
  logic        slot_free, ret_now, fetch_boost;
  logic        win_st, win_ld, win_fe;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;

  assign fetch_boost = starve_cnt_q[2];

  always_comb begin
    starve_cnt_d = 3'd0;
    if (fetch_req && !win_fe) begin
      starve_cnt_d = (starve_cnt_q == 3'd7) ? 3'd7 : starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt_q <= 3'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  assign fetch_boost = 1'b0;
`endif

  // A new grant may coincide with the return cycle of the previous read.
  assign slot_free = (state_q == IDLE) || (busy_cnt_q == 2'd0);
  assign ret_now   = !reset && (state_q == BUSY) && (busy_cnt_q == 2'd0);

  always_comb begin
    win_st = 1'b0;
    win_ld = 1'b0;
    win_fe = 1'b0;
    if (!reset && slot_free) begin
      if (fetch_boost && fetch_req) win_fe = 1'b1;
      else if (st_req)              win_st = 1'b1;
      else if (ld_req)              win_ld = 1'b1;
      else if (fetch_req)           win_fe = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    tag_d      = tag_q;
    if (win_ld || win_fe) begin
      state_d    = BUSY;
      busy_cnt_d = CNT_INIT;
      tag_d      = win_ld;
    end else if (state_q == BUSY) begin
      if (busy_cnt_q == 2'd0) state_d = IDLE;
      else                    busy_cnt_d = busy_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_cnt_q <= 2'd0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    st_gnt       = win_st;
    ld_gnt       = win_ld;
    fetch_gnt    = win_fe;
    mem_en       = win_st || win_ld || win_fe;
    mem_we       = win_st;
    mem_addr     = '0;
    if (win_st)      mem_addr = st_addr;
    else if (win_ld) mem_addr = ld_addr;
    else if (win_fe) mem_addr = fetch_addr;
    mem_wdata    = win_st ? st_data : 16'd0;
    fetch_rvalid = ret_now && !tag_q;
    ld_rvalid    = ret_now && tag_q;
    fetch_rdata  = fetch_rvalid ? mem_rdata : 16'd0;
    ld_rdata     = ld_rvalid ? mem_rdata : 16'd0;
    stall_num    = 3'd0;
    if (!reset) begin
      if ((ld_req && !win_ld) || (st_req && !win_st)) stall_num = 3'd6;
      else if (fetch_req && !win_fe)                  stall_num = 3'd1;
    end
  end

endmodule
